// File: rtl/dec_scan_if.sv
// dec_scan bus: en/mode/x in, y/idx/wrap out.
// master drives selects, slave is the decoder.
interface dec_scan_if #(
  parameter int N    = 3,
  parameter int OUTS = 8
);
  logic            en;
  logic            mode;
  logic [N-1:0]    x;
  logic [OUTS-1:0] y;
  logic [N-1:0]    idx;
  logic            wrap;

  modport master (
    output en, mode, x,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, x,
    output y, idx, wrap
  );
endinterface

// File: rtl/dec_scan.sv
// Registered one-hot decoder with auto-scan (IDLE/DIRECT/SCAN).
// Ports: clk, rst_n (async low), bus (dec_scan_if.slave: en, mode, x -> y, idx, wrap).
// DEC_SCAN_BLANK_EN: one y=0 blanking cycle after each scan dwell.
module dec_scan #(
  parameter int N    = 3,
  parameter int OUTS = 8,
  parameter int DIV  = 4
) (
  input logic       clk,
  input logic       rst_n,
  dec_scan_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CMAX   = CW'(DIV - 1);
  localparam logic [N:0]      OUTS_W = (N+1)'(OUTS);
  localparam logic [N-1:0]    LAST   = N'(OUTS - 1);
  localparam logic [OUTS-1:0] ONE    = OUTS'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t          state_q;
  logic [OUTS-1:0] y_q;
  logic [N-1:0]    idx_q;
  logic            wrap_q;
  logic [CW-1:0]   cnt_q;
`ifdef DEC_SCAN_BLANK_EN
  logic            blank_q;
`endif

  logic         x_ok;
  logic [N-1:0] nxt;
  logic         at_end;
  logic         go_idle;
  logic         go_dir;
  logic         go_entry;
  logic         go_step;

  assign x_ok   = {1'b0, bus.x} < OUTS_W;
  assign nxt    = (idx_q == LAST) ? '0 : idx_q + N'(1);
  assign at_end = cnt_q == CMAX;

  // Mutually exclusive; mode/en changes win over dwell expiry.
  assign go_idle  = !bus.en;
  assign go_dir   = bus.en && !bus.mode;
  assign go_entry = bus.en && bus.mode && (state_q != SCAN);
  assign go_step  = bus.en && bus.mode && (state_q == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DEC_SCAN_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        go_idle: begin
          state_q <= IDLE;
          y_q     <= '0;
          wrap_q  <= 1'b0;
          cnt_q   <= '0;
`ifdef DEC_SCAN_BLANK_EN
          blank_q <= 1'b0;
`endif
        end
        go_dir: begin
          state_q <= DIRECT;
          wrap_q  <= 1'b0;
          cnt_q   <= '0;
`ifdef DEC_SCAN_BLANK_EN
          blank_q <= 1'b0;
`endif
          if (x_ok) begin
            y_q   <= ONE << bus.x;
            idx_q <= bus.x;
          end else begin
            y_q   <= '0;
          end
        end
        go_entry: begin
          state_q <= SCAN;
          wrap_q  <= 1'b0;
          cnt_q   <= '0;
`ifdef DEC_SCAN_BLANK_EN
          blank_q <= 1'b0;
`endif
          if (x_ok) begin
            y_q   <= ONE << bus.x;
            idx_q <= bus.x;
          end else begin
            y_q   <= ONE;
            idx_q <= '0;
          end
        end
        go_step: begin
`ifdef DEC_SCAN_BLANK_EN
          // idx moves at blank start; wrap flags the
          // first re-drive of position 0.
          if (blank_q) begin
            blank_q <= 1'b0;
            y_q     <= ONE << idx_q;
            wrap_q  <= (idx_q == '0);
            cnt_q   <= '0;
          end else if (at_end) begin
            blank_q <= 1'b1;
            idx_q   <= nxt;
            y_q     <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            wrap_q  <= 1'b0;
          end
`else
          if (at_end) begin
            idx_q  <= nxt;
            y_q    <= ONE << nxt;
            wrap_q <= (idx_q == LAST);
            cnt_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            wrap_q <= 1'b0;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule
